ps2_player_input: RTL and testbench

PS2_PLAYER_INPUT -- requirements
Module: ps2_player_input

---
 rtl/ps2_player_input_if.sv | 37 +++
 rtl/ps2_player_input.sv | 197 +++++++++++++++++++
 tb/tb_ps2_player_input.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_player_input_if.sv
// ============================================================================
// ps2_player_input_if : PS/2 line inputs and decoded player/receiver outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface ps2_player_input_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] player1_btns;
    logic [4:0] player2_btns;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  player1_btns,
        input  player2_btns,
        input  rx_byte,
        input  rx_valid,
        input  rx_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output player1_btns,
        output player2_btns,
        output rx_byte,
        output rx_valid,
        output rx_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_player_input.sv
// ============================================================================
// ps2_player_input : PS/2 keyboard receiver and two-player button decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_player_input #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  wire logic          clk_25m,
    input  wire logic          rst_n,
    ps2_player_input_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int              c_TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

    logic            r_clk_meta, r_clk_sync, r_clk_prev;
    logic            r_dat_meta, r_dat_sync;
    logic [1:0]      r_state, w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic [c_TW-1:0] r_tcnt;
    logic [7:0]      r_rx_byte;
    logic            r_rx_valid, r_rx_err;
    logic            w_valid_nxt, w_err_nxt;
    logic            r_ext, r_brk;
    logic [9:0]      r_held;
    logic [9:0]      w_mask;
    logic [4:0]      r_p1, r_p2;
    logic            w_fall, w_bit, w_timeout;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= bus.ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= bus.ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_bit     = r_dat_sync;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == c_TMAX);

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_timeout) begin
            w_err_nxt = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: w_err_nxt = w_bit;
                S_STOP: begin
                    w_valid_nxt = w_bit & r_par_ok;
                    w_err_nxt   = ~(w_bit & r_par_ok);
                end
                default: ;
            endcase
        end
    end

    // Frame datapath; the idle-time counter only runs while inside a frame.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'd0;
            r_par_ok   <= 1'b0;
            r_tcnt     <= '0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= w_valid_nxt;
            r_rx_err   <= w_err_nxt;
            if (w_valid_nxt) r_rx_byte <= r_shift;
            if (r_state == S_IDLE || w_fall || w_timeout) r_tcnt <= '0;
            else                                          r_tcnt <= r_tcnt + 1'b1;
            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= ^{r_shift, w_bit};
                    default: ;
                endcase
            end
        end
    end

    // Held-key bit layout: [4:0] player1, [9:5] player2, each {FIRE,RIGHT,LEFT,DOWN,UP}.
    always_comb begin
        w_mask = 10'd0;
        if (!r_ext) begin
            case (r_rx_byte)
                8'h1D:   w_mask = 10'b00000_00001;
                8'h1B:   w_mask = 10'b00000_00010;
                8'h1C:   w_mask = 10'b00000_00100;
                8'h23:   w_mask = 10'b00000_01000;
                8'h34:   w_mask = 10'b00000_10000;
                8'h5A:   w_mask = 10'b10000_00000;
                default: w_mask = 10'd0;
            endcase
        end else begin
            case (r_rx_byte)
                8'h75:   w_mask = 10'b00001_00000;
                8'h72:   w_mask = 10'b00010_00000;
                8'h6B:   w_mask = 10'b00100_00000;
                8'h74:   w_mask = 10'b01000_00000;
                default: w_mask = 10'd0;
            endcase
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_held <= 10'd0;
        end else if (r_rx_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_rx_valid) begin
            if (r_rx_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_rx_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_held <= r_brk ? (r_held & ~w_mask) : (r_held | w_mask);
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
            end
        end
    end

    function automatic logic [4:0] f_prio(input logic [4:0] h);
        if      (h[4]) f_prio = 5'b10000;
        else if (h[0]) f_prio = 5'b00001;
        else if (h[1]) f_prio = 5'b00010;
        else if (h[2]) f_prio = 5'b00100;
        else if (h[3]) f_prio = 5'b01000;
        else           f_prio = 5'b00000;
    endfunction

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_p1 <= 5'd0;
            r_p2 <= 5'd0;
        end else begin
            r_p1 <= f_prio(r_held[4:0]);
            r_p2 <= f_prio(r_held[9:5]);
        end
    end

    assign bus.player1_btns = r_p1;
    assign bus.player2_btns = r_p2;
    assign bus.rx_byte      = r_rx_byte;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.rx_err       = r_rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_player_input.sv
// ============================================================================
// tb_ps2_player_input : directed PS/2 frames with a received-byte scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_player_input;

    localparam int HALF = 8;
    localparam int GAP  = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   obs_err = 0;
    int   exp_err = 0;
    int   valid_cyc = 0;
    int   p1_chg_cyc = 0;
    logic [4:0] prev_p1 = 5'd0;
    logic [7:0] exp_q[$];

    ps2_player_input_if bus ();

    ps2_player_input #(.TIMEOUT_CYCLES(25000)) dut (
        .clk_25m (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (bus.rx_valid || bus.rx_err)
            check("valid_err_exclusive", {31'd0, bus.rx_valid & bus.rx_err}, 32'd0);
        if (bus.rx_err) obs_err++;
        if (bus.rx_valid) begin
            valid_cyc = cyc;
            check("sb_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("rx_byte", {24'd0, bus.rx_byte}, {24'd0, exp_q.pop_front()});
        end
        if (bus.player1_btns !== prev_p1) begin
            p1_chg_cyc = cyc;
            prev_p1    = bus.player1_btns;
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(stop_val);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    initial begin
        #300000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int waited;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        #1;
        check("rst_p1",    {27'd0, bus.player1_btns}, 32'd0);
        check("rst_p2",    {27'd0, bus.player2_btns}, 32'd0);
        check("rst_byte",  {24'd0, bus.rx_byte},      32'd0);
        check("rst_valid", {31'd0, bus.rx_valid},     32'd0);
        check("rst_err",   {31'd0, bus.rx_err},       32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_key(8'h1D);
        check("w_make_p1", {27'd0, bus.player1_btns}, 32'h01);
        check("w_latency", p1_chg_cyc - valid_cyc, 32'd2);
        check("w_make_p2", {27'd0, bus.player2_btns}, 32'h00);
        send_key(8'hF0); send_key(8'h1D);
        check("w_break_p1", {27'd0, bus.player1_btns}, 32'h00);

        send_key(8'hE0); send_key(8'h6B);
        check("p2_left", {27'd0, bus.player2_btns}, 32'h04);
        send_key(8'h5A);
        check("p2_fire_over_left", {27'd0, bus.player2_btns}, 32'h10);
        send_key(8'hF0); send_key(8'h5A);
        check("p2_fire_release", {27'd0, bus.player2_btns}, 32'h04);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h6B);
        check("p2_ext_release", {27'd0, bus.player2_btns}, 32'h00);

        send_key(8'h75);
        check("plain75_p1",   {27'd0, bus.player1_btns}, 32'h00);
        check("plain75_p2",   {27'd0, bus.player2_btns}, 32'h00);
        check("plain75_byte", {24'd0, bus.rx_byte},      32'h75);

        exp_err++;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("badpar_err_cnt", obs_err, exp_err);
        check("badpar_p1",      {27'd0, bus.player1_btns}, 32'h00);
        check("badpar_byte",    {24'd0, bus.rx_byte},      32'h75);
        exp_err++;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("badstop_err_cnt", obs_err, exp_err);
        check("badstop_p1",      {27'd0, bus.player1_btns}, 32'h00);

        send_key(8'hE0);
        exp_err++;
        send_frame(8'h11, 1'b1, 1'b1);
        send_key(8'h75);
        check("err_clears_ext_err", obs_err, exp_err);
        check("err_clears_ext_p2",  {27'd0, bus.player2_btns}, 32'h00);

        exp_err++;
        send_partial(8'h23, 5);
        waited = 0;
        while (obs_err != exp_err && waited < 26000) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_err_cnt", obs_err, exp_err);
        check("timeout_window",  {31'd0, waited >= 24900 && waited <= 25100}, 32'd1);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        send_key(8'h23);
        check("after_timeout_d", {27'd0, bus.player1_btns}, 32'h08);
        send_key(8'h1D);
        check("up_over_right", {27'd0, bus.player1_btns}, 32'h01);

        send_partial(8'h1C, 3);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_p1",   {27'd0, bus.player1_btns}, 32'h00);
        check("async_rst_p2",   {27'd0, bus.player2_btns}, 32'h00);
        check("async_rst_byte", {24'd0, bus.rx_byte},      32'h00);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (GAP) @(negedge clk);
        send_key(8'h1B);
        check("post_rst_down", {27'd0, bus.player1_btns}, 32'h02);
        check("post_rst_err",  obs_err, exp_err);
        check("sb_drained",    exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
